// File: rtl/ascii_codec_pkg.sv
// rtl/ascii_codec_pkg.sv - ASCII constants and Tx state encoding for ascii_num_codec
package ascii_codec_pkg;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_CONVERT,
        TX_SKIP,
        TX_SEND,
        TX_TERM
    } tx_state_e;

endpackage

// File: rtl/bcd_double_dabble.sv
// rtl/bcd_double_dabble.sv - sequential binary to BCD converter, one bit per step
//  clk, reset : clock, synchronous active-high reset
//  load       : capture value, clear BCD register, start conversion
//  step       : advance one double-dabble iteration while busy
//  value      : binary input sampled on load
//  busy       : conversion in progress
//  done       : 1-cycle pulse after the last iteration, bcd valid
//  bcd        : MAX_DIGITS packed BCD nibbles, digit 0 in bits [3:0]
module bcd_double_dabble #(
    parameter int DATA_W     = 32,
    parameter int MAX_DIGITS = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    step,
    input  logic [DATA_W-1:0]       value,
    output logic                    busy,
    output logic                    done,
    output logic [4*MAX_DIGITS-1:0] bcd
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]       shift_reg;
    logic [CNT_W-1:0]        bits_left;
    logic [4*MAX_DIGITS-1:0] adj;

    // Pre-correct every nibble so the following shift yields a valid BCD digit.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
            bcd       <= '0;
            bits_left <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                shift_reg <= value;
                bcd       <= '0;
                bits_left <= CNT_W'(DATA_W);
                busy      <= 1'b1;
            end else if (busy && step) begin
                bcd       <= {adj[4*MAX_DIGITS-2:0], shift_reg[DATA_W-1]};
                shift_reg <= {shift_reg[DATA_W-2:0], 1'b0};
                bits_left <= bits_left - CNT_W'(1);
                if (bits_left == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ascii_num_codec.sv
// rtl/ascii_num_codec.sv - decimal ASCII <-> binary codec between UART byte streams and core
//  clk, reset                : clock, synchronous active-high reset
//  rx_byte, rx_valid         : incoming ASCII characters, 1-cycle strobe
//  rx_value, rx_value_valid  : decoded value (held) and its 1-cycle update pulse
//  rx_error                  : 1-cycle pulse on illegal character or overflow
//  tx_value, tx_start        : value to send, start request (taken only when idle)
//  tx_busy                   : transmit in progress
//  tx_byte, tx_byte_valid    : outgoing ASCII byte, held until tx_byte_ready
//  tx_byte_ready             : downstream accepts tx_byte
module ascii_num_codec
    import ascii_codec_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MAX_DIGITS = 10,
    parameter bit APPEND_CR  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    output logic [DATA_W-1:0] rx_value,
    output logic              rx_value_valid,
    output logic              rx_error,
    input  logic [DATA_W-1:0] tx_value,
    input  logic              tx_start,
    output logic              tx_busy,
    output logic [7:0]        tx_byte,
    output logic              tx_byte_valid,
    input  logic              tx_byte_ready
);

    localparam int IDX_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
    localparam int CNT_W = 4;

    // ---------------- Rx accumulator ----------------
    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  digit_cnt;
    logic              ovf;
    logic [DATA_W+3:0] acc_ext;
    logic [DATA_W+3:0] acc_nxt;
    logic              is_digit;
    logic              is_term;

    always_comb begin
        is_digit = (rx_byte >= ASCII_0) && (rx_byte <= ASCII_9);
        is_term  = (rx_byte == ASCII_CR) || (rx_byte == ASCII_LF);
        acc_ext  = {4'b0, acc};
        // acc*10 as (acc<<3)+(acc<<1); the 4 extra bits expose overflow.
        acc_nxt  = (acc_ext << 3) + (acc_ext << 1) + {{DATA_W{1'b0}}, rx_byte[3:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc            <= '0;
            digit_cnt      <= '0;
            ovf            <= 1'b0;
            rx_value       <= '0;
            rx_value_valid <= 1'b0;
            rx_error       <= 1'b0;
        end else begin
            rx_value_valid <= 1'b0;
            rx_error       <= 1'b0;
            if (rx_valid) begin
                if (is_digit) begin
                    if (acc_nxt[DATA_W+3:DATA_W] != 4'd0) begin
                        ovf <= 1'b1;
                    end else begin
                        acc <= acc_nxt[DATA_W-1:0];
                    end
                    if (digit_cnt != '1) begin
                        digit_cnt <= digit_cnt + CNT_W'(1);
                    end
                end else if (is_term) begin
                    // Empty lines and the second half of CRLF are silently dropped.
                    if (digit_cnt != '0) begin
                        if (ovf) begin
                            rx_error <= 1'b1;
                        end else begin
                            rx_value       <= acc;
                            rx_value_valid <= 1'b1;
                        end
                        acc       <= '0;
                        digit_cnt <= '0;
                        ovf       <= 1'b0;
                    end
                end else begin
                    rx_error  <= 1'b1;
                    acc       <= '0;
                    digit_cnt <= '0;
                    ovf       <= 1'b0;
                end
            end
        end
    end

    // ---------------- Tx serializer ----------------
    tx_state_e               tx_state;
    logic [IDX_W-1:0]        idx;
    logic                    dd_load;
    logic                    dd_step;
    logic                    dd_busy;
    logic                    dd_done;
    logic [4*MAX_DIGITS-1:0] dd_bcd;
    logic [3:0]              digits [MAX_DIGITS];

    for (genvar g = 0; g < MAX_DIGITS; g++) begin : g_digits
        assign digits[g] = dd_bcd[4*g +: 4];
    end

    assign dd_load = (tx_state == TX_IDLE) && tx_start && !dd_busy;
    assign dd_step = (tx_state == TX_CONVERT);

    bcd_double_dabble #(
        .DATA_W     (DATA_W),
        .MAX_DIGITS (MAX_DIGITS)
    ) u_dd (
        .clk   (clk),
        .reset (reset),
        .load  (dd_load),
        .step  (dd_step),
        .value (tx_value),
        .busy  (dd_busy),
        .done  (dd_done),
        .bcd   (dd_bcd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state      <= TX_IDLE;
            idx           <= '0;
            tx_busy       <= 1'b0;
            tx_byte       <= '0;
            tx_byte_valid <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (dd_load) begin
                        tx_busy  <= 1'b1;
                        tx_state <= TX_CONVERT;
                    end
                end
                TX_CONVERT: begin
                    if (dd_done) begin
                        idx      <= IDX_W'(MAX_DIGITS - 1);
                        tx_state <= TX_SKIP;
                    end
                end
                TX_SKIP: begin
                    // Digit 0 is always sent, so a zero value still yields "0".
                    if (digits[idx] == 4'd0 && idx != '0) begin
                        idx <= idx - IDX_W'(1);
                    end else begin
                        tx_byte       <= ASCII_0 + {4'b0, digits[idx]};
                        tx_byte_valid <= 1'b1;
                        tx_state      <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (tx_byte_ready) begin
                        if (idx == '0) begin
                            if (APPEND_CR) begin
                                tx_byte  <= ASCII_CR;
                                tx_state <= TX_TERM;
                            end else begin
                                tx_byte_valid <= 1'b0;
                                tx_busy       <= 1'b0;
                                tx_state      <= TX_IDLE;
                            end
                        end else begin
                            tx_byte <= ASCII_0 + {4'b0, digits[idx - IDX_W'(1)]};
                            idx     <= idx - IDX_W'(1);
                        end
                    end
                end
                TX_TERM: begin
                    if (tx_byte_ready) begin
                        tx_byte_valid <= 1'b0;
                        tx_busy       <= 1'b0;
                        tx_state      <= TX_IDLE;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_num_codec.sv
// tb/tb_ascii_num_codec.sv - scoreboard testbench for ascii_num_codec
module tb_ascii_num_codec;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [31:0] rx_value;
    logic        rx_value_valid;
    logic        rx_error;
    logic [31:0] tx_value;
    logic        tx_start;
    logic        tx_busy;
    logic [7:0]  tx_byte;
    logic        tx_byte_valid;
    logic        tx_byte_ready;

    logic [7:0]  rx_byte2;
    logic        rx_valid2;
    logic [31:0] rx_value2;
    logic        rx_value_valid2;
    logic        rx_error2;
    logic [31:0] tx_value2;
    logic        tx_start2;
    logic        tx_busy2;
    logic [7:0]  tx_byte2;
    logic        tx_byte_valid2;
    logic        tx_byte_ready2;

    always #5 clk = ~clk;

    ascii_num_codec #(.DATA_W(32), .MAX_DIGITS(10), .APPEND_CR(1'b1)) u_dut (
        .clk(clk), .reset(reset),
        .rx_byte(rx_byte), .rx_valid(rx_valid),
        .rx_value(rx_value), .rx_value_valid(rx_value_valid), .rx_error(rx_error),
        .tx_value(tx_value), .tx_start(tx_start), .tx_busy(tx_busy),
        .tx_byte(tx_byte), .tx_byte_valid(tx_byte_valid), .tx_byte_ready(tx_byte_ready)
    );

    ascii_num_codec #(.DATA_W(32), .MAX_DIGITS(10), .APPEND_CR(1'b0)) u_dut_nocr (
        .clk(clk), .reset(reset),
        .rx_byte(rx_byte2), .rx_valid(rx_valid2),
        .rx_value(rx_value2), .rx_value_valid(rx_value_valid2), .rx_error(rx_error2),
        .tx_value(tx_value2), .tx_start(tx_start2), .tx_busy(tx_busy2),
        .tx_byte(tx_byte2), .tx_byte_valid(tx_byte_valid2), .tx_byte_ready(tx_byte_ready2)
    );

    typedef struct packed {
        logic        is_err;
        logic [31:0] val;
    } rx_exp_t;

    int          vectors     = 0;
    int          miscompares = 0;
    rx_exp_t     rx_q[$];
    logic [7:0]  tx_q[$];
    logic [7:0]  tx2_q[$];
    int          tx_popped   = 0;
    logic        stall_prev  = 1'b0;
    logic [7:0]  prev_byte   = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor for the main instance: pops expectations whenever an output event appears.
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (rx_value_valid || rx_error) begin
                if (rx_q.size() == 0) begin
                    fail_now("rx_unexpected_event");
                end else begin
                    rx_exp_t e;
                    e = rx_q.pop_front();
                    check("rx_error_flag", {31'b0, rx_error}, {31'b0, e.is_err});
                    check("rx_value", rx_value, e.val);
                end
            end
            if (stall_prev && tx_byte_valid) begin
                check("tx_byte_hold", {24'b0, tx_byte}, {24'b0, prev_byte});
            end
            if (tx_byte_valid && tx_byte_ready) begin
                if (tx_q.size() == 0) begin
                    fail_now("tx_unexpected_byte");
                end else begin
                    logic [7:0] b;
                    b = tx_q.pop_front();
                    check("tx_byte", {24'b0, tx_byte}, {24'b0, b});
                end
                tx_popped++;
            end
            stall_prev = tx_byte_valid && !tx_byte_ready;
            prev_byte  = tx_byte;
        end
    end

    always @(negedge clk) begin
        if (!reset && tx_byte_valid2 && tx_byte_ready2) begin
            if (tx2_q.size() == 0) begin
                fail_now("tx_nocr_unexpected_byte");
            end else begin
                logic [7:0] b;
                b = tx2_q.pop_front();
                check("tx_nocr_byte", {24'b0, tx_byte2}, {24'b0, b});
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rx_send(input logic [7:0] b, input int gap);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick(gap);
    endtask

    task automatic rx_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            rx_send(s[i], gap);
        end
    endtask

    task automatic rx_drain(input string name);
        int n;
        n = 0;
        while (rx_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        if (rx_q.size() != 0) begin
            fail_now(name);
            rx_q.delete();
        end
    endtask

    // Pushes the hand-written expected byte string, then issues the start pulse.
    task automatic tx_begin(input logic [31:0] v, input string s);
        int n;
        n = 0;
        while (tx_busy && n < 500) begin
            tick();
            n++;
        end
        for (int i = 0; i < s.len(); i++) begin
            tx_q.push_back(s[i]);
        end
        tx_q.push_back(8'h0D);
        tx_value = v;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        check("tx_busy_after_start", {31'b0, tx_busy}, 32'd1);
    endtask

    task automatic tx_wait_done(input string name);
        int n;
        n = 0;
        while ((tx_q.size() != 0 || tx_busy) && n < 500) begin
            tick();
            n++;
        end
        if (tx_q.size() != 0 || tx_busy) begin
            fail_now(name);
            tx_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_value"}, rx_value, 32'd0);
        check({tag, "_rx_value_valid"}, {31'b0, rx_value_valid}, 32'd0);
        check({tag, "_rx_error"}, {31'b0, rx_error}, 32'd0);
        check({tag, "_tx_busy"}, {31'b0, tx_busy}, 32'd0);
        check({tag, "_tx_byte_valid"}, {31'b0, tx_byte_valid}, 32'd0);
        check({tag, "_tx_byte"}, {24'b0, tx_byte}, 32'd0);
    endtask

    initial begin
        int n;
        int base;
        reset          = 1'b1;
        rx_byte        = 8'h00;
        rx_valid       = 1'b0;
        tx_value       = '0;
        tx_start       = 1'b0;
        tx_byte_ready  = 1'b1;
        rx_byte2       = 8'h00;
        rx_valid2      = 1'b0;
        tx_value2      = '0;
        tx_start2      = 1'b0;
        tx_byte_ready2 = 1'b1;
        tick(3);
        check_reset_outputs("reset");
        reset = 1'b0;
        tick(2);

        // 1: "123" CR on spaced strobes, pulse one cycle after CR, trailing LF ignored
        rx_str("123", 2);
        rx_q.push_back('{is_err: 1'b0, val: 32'd123});
        rx_send(8'h0D, 0);
        check("rx_valid_latency", {31'b0, rx_value_valid}, 32'd1);
        tick(3);
        rx_send(8'h0A, 4);
        rx_drain("rx_drain_t1");

        // 2: maximum value, overflow by one, then recovery
        rx_q.push_back('{is_err: 1'b0, val: 32'hFFFF_FFFF});
        rx_str("4294967295", 0);
        rx_send(8'h0D, 2);
        rx_q.push_back('{is_err: 1'b1, val: 32'hFFFF_FFFF});
        rx_str("4294967296", 1);
        rx_send(8'h0D, 2);
        rx_q.push_back('{is_err: 1'b0, val: 32'd7});
        rx_str("7", 0);
        rx_send(8'h0A, 2);
        rx_drain("rx_drain_t2");

        // 3: illegal char clears state; following CR is empty; leading zero accepted
        rx_q.push_back('{is_err: 1'b1, val: 32'd7});
        rx_send("1", 1);
        rx_send("A", 0);
        check("rx_error_latency", {31'b0, rx_error}, 32'd1);
        tick(2);
        rx_send(8'h0D, 3);
        rx_q.push_back('{is_err: 1'b0, val: 32'd5});
        rx_str("05", 0);
        rx_send(8'h0D, 2);
        rx_drain("rx_drain_t3");

        // 4: Tx values, and the no-terminator build
        tx_begin(32'd0, "0");
        tx_wait_done("tx_timeout_0");
        tx_begin(32'hFFFF_FFFF, "4294967295");
        tx_wait_done("tx_timeout_max");
        tx_begin(32'd1000, "1000");
        tx_wait_done("tx_timeout_1000");
        tx2_q.push_back("4");
        tx2_q.push_back("2");
        tx_value2 = 32'd42;
        tx_start2 = 1'b1;
        tick();
        tx_start2 = 1'b0;
        n = 0;
        while ((tx2_q.size() != 0 || tx_busy2) && n < 200) begin
            tick();
            n++;
        end
        tick(5);
        check("tx_nocr_done", {31'b0, tx_busy2}, 32'd0);
        check("tx_nocr_remaining", tx2_q.size(), 32'd0);

        // 5: back-pressure mid-stream and ignored start pulses while busy
        base = tx_popped;
        tx_begin(32'hFFFF_FFFF, "4294967295");
        tick(5);
        tx_value = 32'd5;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        n = 0;
        while (tx_popped < base + 3 && n < 200) begin
            tick();
            n++;
        end
        if (tx_popped < base + 3) fail_now("tx_stall_wait_timeout");
        tx_byte_ready = 1'b0;
        tick(2);
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        tick(2);
        tx_byte_ready = 1'b1;
        tx_wait_done("tx_timeout_stall");
        tick(5);
        check("tx_idle_after_stall", {31'b0, tx_byte_valid}, 32'd0);

        // 6a: concurrent Rx decode while a Tx is running
        fork
            begin
                tx_begin(32'd1000, "1000");
                tx_wait_done("tx_timeout_concurrent");
            end
            begin
                tick(3);
                rx_q.push_back('{is_err: 1'b0, val: 32'd123456});
                rx_str("123456", 1);
                rx_send(8'h0D, 1);
            end
        join
        rx_drain("rx_drain_concurrent");

        // 6b: reset during CONVERT
        tx_begin(32'hFFFF_FFFF, "4294967295");
        tick(10);
        reset = 1'b1;
        tick();
        check_reset_outputs("rst_convert");
        reset = 1'b0;
        tx_q.delete();
        tick(40);
        check("post_rst_convert_quiet", {31'b0, tx_byte_valid}, 32'd0);

        // 6c: reset during SEND
        base = tx_popped;
        tx_begin(32'd1000, "1000");
        n = 0;
        while (tx_popped < base + 2 && n < 200) begin
            tick();
            n++;
        end
        if (tx_popped < base + 2) fail_now("tx_send_wait_timeout");
        reset = 1'b1;
        tick();
        check_reset_outputs("rst_send");
        reset = 1'b0;
        tx_q.delete();
        tick(3);
        tx_begin(32'd9, "9");
        tx_wait_done("tx_timeout_9");

        tick(5);
        check("final_tx_queue", tx_q.size(), 32'd0);
        check("final_rx_queue", rx_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
